sld_stream_feeder: RTL and testbench

- Synthesizable successor to the bench-side scene-data feeder.
- Holds a preloaded scene image in an internal synchronous RAM and serves it word by word to the CPU core over the readflag-style request/valid handshake.
- Generalised in data width, depth and mode (one-shot or loop), with underrun detection.
- Sits between the host loader path and the core's receive input (recvdata/recv_valid).

---
 rtl/sld_feeder_pkg.sv | 16 +
 rtl/sld_feeder_ram.sv | 28 ++
 rtl/sld_stream_feeder.sv | 175 +++++++++++++++++
 tb/tb_sld_stream_feeder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sld_feeder_pkg.sv
// Shared types and default sizing for the scene-data stream feeder.
package sld_feeder_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    READ,
    PRESENT,
    WAIT_DROP,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/sld_feeder_ram.sv
// Image store: one write port, one registered read port (1-cycle latency), no reset.
module sld_feeder_ram
  import sld_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sld_stream_feeder.sv
// Serves a preloaded scene image word by word over the readflag req/valid handshake.
// Define SLD_FEEDER_CHECKSUM_EN to add the served_cnt / checksum observability outputs.
module sld_stream_feeder
  import sld_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_len_we,
  input  logic [ADDR_W:0]   load_len,
  input  logic              start,
  input  logic              loop_mode,
  input  logic              req,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              underrun
`ifdef SLD_FEEDER_CHECKSUM_EN
  ,
  output logic [31:0]       served_cnt,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  feeder_state_t     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              loop_q, loop_d;
  logic              last_q, last_d;
  logic              under_q, under_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req_q;
  logic              valid_q, busy_q, done_q;
  logic              load_ok;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign load_ok = (state_q == IDLE) || (state_q == DONE);

  sld_feeder_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (load_we & load_ok),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (ram_re),
    .raddr (ptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    loop_d  = loop_q;
    last_d  = last_q;
    under_d = under_q;
    data_d  = data_q;
    ram_re  = 1'b0;

    if (load_len_we && load_ok) len_d = (load_len > LEN_MAX) ? LEN_MAX : load_len;

    // start wins over every state, including an in-flight read, which is dropped.
    if (start) begin
      ptr_d   = '0;
      loop_d  = loop_mode;
      last_d  = 1'b0;
      under_d = 1'b0;
      state_d = (len_q == '0) ? DONE : WAIT_REQ;
    end else begin
      case (state_q)
        WAIT_REQ: begin
          if (req) begin
            ram_re  = 1'b1;
            state_d = READ;
          end
        end
        READ: begin
          data_d  = ram_rdata;
          state_d = PRESENT;
        end
        PRESENT: begin
          if ({1'b0, ptr_q} == len_q - LEN_ONE) begin
            if (loop_q) begin
              ptr_d = '0;
            end else begin
              ptr_d  = ptr_q + PTR_ONE;
              last_d = 1'b1;
            end
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
          state_d = WAIT_DROP;
        end
        WAIT_DROP: begin
          if (!req) state_d = last_q ? DONE : WAIT_REQ;
        end
        DONE: begin
          if (req && !req_q) under_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      last_q  <= 1'b0;
      under_q <= 1'b0;
      data_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      last_q  <= last_d;
      under_q <= under_d;
      data_q  <= data_d;
      req_q   <= req;
      valid_q <= (state_d == PRESENT);
      busy_q  <= (state_d inside {WAIT_REQ, READ, PRESENT, WAIT_DROP});
      done_q  <= (state_d == DONE);
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = under_q;

`ifdef SLD_FEEDER_CHECKSUM_EN
  logic [31:0] cnt_q, sum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
      sum_q <= '0;
    end else if (valid_q) begin
      cnt_q <= cnt_q + 32'd1;
      sum_q <= sum_q + 32'(data_q);
    end
  end

  assign served_cnt = cnt_q;
  assign checksum   = sum_q;
`endif

endmodule

// File: tb/tb_sld_stream_feeder.sv
// Randomized self-checking bench for sld_stream_feeder against a word-list reference model.
// Checksum outputs are checked when SLD_FEEDER_CHECKSUM_EN is defined.
module tb_sld_stream_feeder;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          load_we, load_len_we, start, loop_mode, req;
  logic [3:0]    load_addr;
  logic [DW-1:0] load_data;
  logic [4:0]    load_len;
  logic [DW-1:0] data_out;
  logic          valid, busy, done, underrun;
`ifdef SLD_FEEDER_CHECKSUM_EN
  logic [31:0]   served_cnt, checksum;
`endif

  int errors = 0;
  int checks = 0;

  sld_stream_feeder #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rstn(rstn),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_len_we(load_len_we), .load_len(load_len),
    .start(start), .loop_mode(loop_mode), .req(req),
    .data_out(data_out), .valid(valid), .busy(busy), .done(done), .underrun(underrun)
`ifdef SLD_FEEDER_CHECKSUM_EN
    , .served_cnt(served_cnt), .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the image as a word list plus the read index since start.
  logic [DW-1:0] img [DP];
  int            mlen, midx;
  bit            mloop, mdone, mbusy, munder;
  int unsigned   mcnt, msum;

  task automatic m_reset();
    mlen = 0; midx = 0; mloop = 0; mdone = 0; mbusy = 0; munder = 0; mcnt = 0; msum = 0;
  endtask

  task automatic m_start(input bit lp);
    midx = 0; mloop = lp; munder = 0; mcnt = 0; msum = 0;
    mdone = (mlen == 0); mbusy = !mdone;
  endtask

  task automatic m_req(output bit ev, output logic [DW-1:0] ed);
    if (mdone) begin
      ev = 0; ed = '0; munder = 1;
    end else begin
      ev = 1; ed = img[midx];
      mcnt++; msum += ed;
      midx++;
      if (midx == mlen) begin
        if (mloop) midx = 0;
        else begin mdone = 1; mbusy = 0; end
      end
    end
  endtask

  // Drivers: every task starts and ends 1 time unit after a rising edge.
  task automatic apply_reset();
    rstn = 0; req = 0; start = 0; load_we = 0; load_len_we = 0; loop_mode = 0;
    load_addr = '0; load_data = '0; load_len = '0;
    @(posedge clk); #1;
    rstn = 1;
    m_reset();
  endtask

  task automatic drv_load(input logic [3:0] a, input logic [DW-1:0] d);
    load_we = 1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_we = 0;
    if (!mbusy) img[a] = d;
  endtask

  task automatic drv_len(input logic [4:0] l);
    load_len_we = 1; load_len = l;
    @(posedge clk); #1;
    load_len_we = 0;
    if (!mbusy) mlen = (int'(l) > DP) ? DP : int'(l);
  endtask

  task automatic drv_start(input bit lp);
    start = 1; loop_mode = lp;
    @(posedge clk); #1;
    start = 0;
    m_start(lp);
  endtask

  // Raise req for 'hold' cycles, then drop it and let two more edges pass.
  task automatic do_req(input int hold, output logic got, output logic [DW-1:0] d,
                        output int lat, output int nv);
    got = 0; d = '0; lat = 0; nv = 0;
    req = 1;
    for (int c = 1; c <= hold; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        nv++;
        if (!got) begin got = 1; d = data_out; lat = c; end
      end
    end
    req = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
  endtask

  task automatic load_abc();
    drv_load(4'd0, 8'h0A); drv_load(4'd1, 8'h09); drv_load(4'd2, 8'h55);
    drv_len(5'd3);
  endtask

  task automatic test_reset();
    rstn = 0; req = 0; start = 0; load_we = 0; load_len_we = 0; loop_mode = 0;
    load_addr = '0; load_data = '0; load_len = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", data_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b exp 0", underrun); end
`ifdef SLD_FEEDER_CHECKSUM_EN
    checks++; if (served_cnt !== 32'd0 || checksum !== 32'd0) begin
      errors++; $display("FAIL reset_cksum: got %0d/%h exp 0/0", served_cnt, checksum); end
`endif
    rstn = 1;
    m_reset();
  endtask

  task automatic test_len_zero();
    logic got; logic [DW-1:0] d; int lat, nv, bz;
    apply_reset();
    drv_len(5'd0);
    drv_start(0);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL len0_done: got done=%b busy=%b exp 1/0", done, busy); end
    bz = 0;
    repeat (4) begin @(posedge clk); #1; if (busy) bz++; end
    checks++; if (bz != 0) begin errors++; $display("FAIL len0_busy: got %0d busy cycles exp 0", bz); end
    load_abc();
    drv_start(0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL armed_busy: got %b exp 1", busy); end
    drv_load(4'd0, 8'hFF);
    do_req(4, got, d, lat, nv);
    checks++; if (got !== 1'b1 || d !== 8'h0A) begin
      errors++; $display("FAIL load_ignored: got valid=%b data=%h exp 1/0a", got, d); end
  endtask

  task automatic test_oneshot();
    logic got; logic [DW-1:0] d; int lat, nv;
    logic [DW-1:0] exp_w [3];
    exp_w[0] = 8'h0A; exp_w[1] = 8'h09; exp_w[2] = 8'h55;
    apply_reset();
    load_abc();
    drv_start(0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL oneshot_early_done%0d: got %b exp 0", i, done); end
      do_req(3, got, d, lat, nv);
      checks++; if (got !== 1'b1 || d !== exp_w[i] || lat != 2 || nv != 1) begin
        errors++; $display("FAIL oneshot_word%0d: got v=%b d=%h lat=%0d n=%0d exp 1/%h/2/1", i, got, d, lat, nv, exp_w[i]); end
      checks++; if (data_out !== exp_w[i]) begin
        errors++; $display("FAIL oneshot_hold%0d: got %h exp %h", i, data_out, exp_w[i]); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL oneshot_done: got done=%b busy=%b exp 1/0", done, busy); end
`ifdef SLD_FEEDER_CHECKSUM_EN
    checks++; if (served_cnt !== 32'd3 || checksum !== 32'h68) begin
      errors++; $display("FAIL oneshot_cksum: got %0d/%h exp 3/68", served_cnt, checksum); end
`endif
  endtask

  task automatic test_hold_req();
    logic got; logic [DW-1:0] d; int lat, nv;
    apply_reset();
    load_abc();
    drv_start(0);
    do_req(10, got, d, lat, nv);
    checks++; if (nv != 1 || d !== 8'h0A) begin
      errors++; $display("FAIL held_req: got %0d valids data=%h exp 1/0a", nv, d); end
    do_req(3, got, d, lat, nv);
    checks++; if (got !== 1'b1 || d !== 8'h09) begin
      errors++; $display("FAIL held_next: got v=%b d=%h exp 1/09", got, d); end
  endtask

  task automatic test_loop();
    logic got; logic [DW-1:0] d; int lat, nv;
    logic [DW-1:0] exp_w [5];
    exp_w[0] = 8'h0A; exp_w[1] = 8'h09; exp_w[2] = 8'h55; exp_w[3] = 8'h0A; exp_w[4] = 8'h09;
    apply_reset();
    load_abc();
    drv_start(1);
    for (int i = 0; i < 5; i++) begin
      do_req(3, got, d, lat, nv);
      checks++; if (got !== 1'b1 || d !== exp_w[i] || done !== 1'b0) begin
        errors++; $display("FAIL loop_word%0d: got v=%b d=%h done=%b exp 1/%h/0", i, got, d, done, exp_w[i]); end
    end
  endtask

  task automatic test_underrun();
    logic got; logic [DW-1:0] d; int lat, nv;
    apply_reset();
    drv_load(4'd0, 8'h0A); drv_load(4'd1, 8'h09); drv_len(5'd2);
    drv_start(0);
    do_req(3, got, d, lat, nv);
    do_req(3, got, d, lat, nv);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL under_early: got %b exp 0", underrun); end
    do_req(4, got, d, lat, nv);
    checks++; if (nv != 0 || underrun !== 1'b1) begin
      errors++; $display("FAIL under_set: got valids=%0d underrun=%b exp 0/1", nv, underrun); end
    drv_start(0);
    checks++; if (underrun !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL under_clear: got underrun=%b done=%b exp 0/0", underrun, done); end
    do_req(3, got, d, lat, nv);
    checks++; if (got !== 1'b1 || d !== 8'h0A) begin
      errors++; $display("FAIL under_restart: got v=%b d=%h exp 1/0a", got, d); end
  endtask

  task automatic test_restart_mid();
    logic got; logic [DW-1:0] d; int lat, nv, vc;
    apply_reset();
    load_abc();
    drv_start(0);
    do_req(3, got, d, lat, nv);
    req = 1;
    @(posedge clk); #1;
    start = 1; loop_mode = 0; req = 0;
    @(posedge clk); #1;
    start = 0;
    m_start(0);
    vc = valid ? 1 : 0;
    repeat (3) begin @(posedge clk); #1; if (valid) vc++; end
    checks++; if (vc != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_novalid: got valids=%0d busy=%b exp 0/1", vc, busy); end
    do_req(3, got, d, lat, nv);
    checks++; if (got !== 1'b1 || d !== 8'h0A) begin
      errors++; $display("FAIL restart_word0: got v=%b d=%h exp 1/0a", got, d); end
  endtask

  task automatic test_load_start_same();
    logic got; logic [DW-1:0] d; int lat, nv;
    apply_reset();
    drv_load(4'd0, 8'h11); drv_len(5'd1);
    drv_start(0);
    do_req(3, got, d, lat, nv);
    start = 1; loop_mode = 0; load_we = 1; load_addr = 4'd0; load_data = 8'hC3;
    @(posedge clk); #1;
    start = 0; load_we = 0;
    img[0] = 8'hC3; m_start(0);
    do_req(3, got, d, lat, nv);
    checks++; if (got !== 1'b1 || d !== 8'hC3 || lat != 2) begin
      errors++; $display("FAIL start_load_same: got v=%b d=%h lat=%0d exp 1/c3/2", got, d, lat); end
  endtask

  task automatic test_saturate();
    logic got; logic [DW-1:0] d; int lat, nv, bad;
    bit ev; logic [DW-1:0] ed;
    apply_reset();
    for (int a = 0; a < DP; a++) drv_load(4'(a), 8'($urandom));
    drv_len(5'd31);
    drv_start(0);
    bad = 0;
    for (int i = 0; i < DP; i++) begin
      do_req(3, got, d, lat, nv); m_req(ev, ed);
      if (got !== 1'b1 || d !== ed) bad++;
    end
    checks++; if (bad != 0 || done !== 1'b1) begin
      errors++; $display("FAIL sat_len: got %0d bad words done=%b exp 0/1", bad, done); end
    do_req(3, got, d, lat, nv); m_req(ev, ed);
    checks++; if (nv != 0 || underrun !== 1'b1) begin
      errors++; $display("FAIL sat_underrun: got valids=%0d underrun=%b exp 0/1", nv, underrun); end
  endtask

  task automatic test_random();
    logic got; logic [DW-1:0] d; int lat, nv, nreq;
    bit ev; logic [DW-1:0] ed;
    for (int it = 0; it < 6; it++) begin
      apply_reset();
      for (int a = 0; a < DP; a++) drv_load(4'(a), 8'($urandom));
      drv_len(5'($urandom_range(1, DP)));
      drv_start(1'($urandom_range(0, 1)));
      nreq = $urandom_range(1, 2 * mlen + 2);
      for (int r = 0; r < nreq; r++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #0;
        do_req($urandom_range(3, 6), got, d, lat, nv);
        m_req(ev, ed);
        checks++; if (got !== ev || nv != int'(ev)) begin
          errors++; $display("FAIL rand_valid it%0d r%0d: got v=%b n=%0d exp %b", it, r, got, nv, ev); end
        if (ev) begin
          checks++; if (d !== ed || lat != 2) begin
            errors++; $display("FAIL rand_data it%0d r%0d: got %h lat=%0d exp %h/2", it, r, d, lat, ed); end
        end
        checks++; if (busy !== mbusy || done !== mdone || underrun !== munder) begin
          errors++; $display("FAIL rand_flags it%0d r%0d: got b/d/u=%b%b%b exp %b%b%b",
                             it, r, busy, done, underrun, mbusy, mdone, munder); end
      end
`ifdef SLD_FEEDER_CHECKSUM_EN
      checks++; if (served_cnt !== mcnt || checksum !== msum) begin
        errors++; $display("FAIL rand_cksum it%0d: got %0d/%h exp %0d/%h", it, served_cnt, checksum, mcnt, msum); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int c;
    apply_reset();
    load_abc();
    drv_start(0);
    req = 1;
    c = 0;
    while (!valid && c < 6) begin @(posedge clk); #1; c++; end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid: got %b exp 1", valid); end
    #2 rstn = 0;
    #1;
    checks++; if (valid !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00 || done !== 1'b0 || underrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: got v=%b b=%b d=%h dn=%b u=%b exp all 0",
                         valid, busy, data_out, done, underrun); end
    req = 0;
    @(posedge clk); #1;
    rstn = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got b=%b dn=%b v=%b exp 0/0/0", busy, done, valid); end
  endtask

  initial begin
    test_reset();
    test_len_zero();
    test_oneshot();
    test_hold_req();
    test_loop();
    test_underrun();
    test_restart_mid();
    test_load_start_same();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
